// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I/RV32E core on a single valid/ready memory bus.
// Define RV32_ALIGN_CHECK_EN to trap misaligned accesses and jump targets.
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS   = 32,
    parameter int          ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] mem_addr,
    output logic        mem_valid,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic        trap,
    output logic [31:0] dbg_x1
);

    localparam int RW = $clog2(NUM_REGS);
    localparam bit IS_E = (NUM_REGS == 16);
    localparam logic [31:0] AMASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : 32'((64'd1 << ADDR_WIDTH) - 64'd1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT_INSTR, S_DECODE, S_EXECUTE,
        S_MEM, S_WAIT_DATA, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        trap_q, trap_d;
    logic [31:0] rf_q [NUM_REGS];

    logic          rf_we;
    logic [RW-1:0] rf_wa;
    logic [31:0]   rf_wd;

    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_wdata;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu, ea, tgt, pc_plus4;
    logic [31:0] ld_val, st_wdata;
    logic [15:0] ld_h;
    logic [7:0]  ld_b;
    logic [3:0]  st_mask;
    logic        taken, br_ok, mis_ls, mis_tgt, e_bad;
    logic        use_rd, use_rs1, use_rs2;

    assign opcode = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign f_rd   = instr_q[11:7];
    assign f_rs1  = instr_q[19:15];
    assign f_rs2  = instr_q[24:20];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u  = {instr_q[31:12], 12'd0};
    assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                     instr_q[20], instr_q[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        op_b = (opcode == OP_REG) ? rs2_q : imm_i;
        case (f3)
            3'd0: alu = (opcode == OP_REG && instr_q[30]) ? rs1_q - op_b
                                                        : rs1_q + op_b;
            3'd1: alu = rs1_q << op_b[4:0];
            3'd2: alu = {31'd0, $signed(rs1_q) < $signed(op_b)};
            3'd3: alu = {31'd0, rs1_q < op_b};
            3'd4: alu = rs1_q ^ op_b;
            3'd5: alu = instr_q[30] ? 32'($signed(rs1_q) >>> op_b[4:0])
                                    : rs1_q >> op_b[4:0];
            3'd6: alu = rs1_q | op_b;
            default: alu = rs1_q & op_b;
        endcase

        br_ok = 1'b1;
        case (f3)
            3'd0: taken = (rs1_q == rs2_q);
            3'd1: taken = (rs1_q != rs2_q);
            3'd4: taken = ($signed(rs1_q) < $signed(rs2_q));
            3'd5: taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'd6: taken = (rs1_q < rs2_q);
            3'd7: taken = (rs1_q >= rs2_q);
            default: begin
                taken = 1'b0;
                br_ok = 1'b0;
            end
        endcase

        ea = rs1_q + ((opcode == OP_STORE) ? imm_s : imm_i);
        case (opcode)
            OP_JAL:  tgt = pc_q + imm_j;
            OP_JALR: tgt = (rs1_q + imm_i) & ~32'd1;
            default: tgt = pc_q + imm_b;
        endcase

`ifdef RV32_ALIGN_CHECK_EN
        mis_ls  = (f3[1:0] == 2'b10 && ea[1:0] != 2'b00) ||
                  (f3[1:0] == 2'b01 && ea[0]);
        mis_tgt = (tgt[1:0] != 2'b00);
`else
        mis_ls  = 1'b0;
        mis_tgt = 1'b0;
`endif

        // halfword at byte 3 wraps to lane 0 of the same word
        case (addr_q[1:0])
            2'd0: begin ld_b = rdata_q[7:0];   ld_h = rdata_q[15:0]; end
            2'd1: begin ld_b = rdata_q[15:8];  ld_h = rdata_q[23:8]; end
            2'd2: begin ld_b = rdata_q[23:16]; ld_h = rdata_q[31:16]; end
            default: begin
                ld_b = rdata_q[31:24];
                ld_h = {rdata_q[7:0], rdata_q[31:24]};
            end
        endcase
        case (f3)
            3'd0: ld_val = {{24{ld_b[7]}}, ld_b};
            3'd1: ld_val = {{16{ld_h[15]}}, ld_h};
            3'd4: ld_val = {24'd0, ld_b};
            3'd5: ld_val = {16'd0, ld_h};
            default: ld_val = rdata_q;
        endcase

        case (f3[1:0])
            2'd0: begin
                st_mask  = 4'b0001 << addr_q[1:0];
                st_wdata = {4{rs2_q[7:0]}};
            end
            2'd1: begin
                case (addr_q[1:0])
                    2'd0: st_mask = 4'b0011;
                    2'd1: st_mask = 4'b0110;
                    2'd2: st_mask = 4'b1100;
                    default: st_mask = 4'b1001;
                endcase
                st_wdata = addr_q[0] ? {2{rs2_q[7:0], rs2_q[15:8]}}
                                     : {2{rs2_q[15:0]}};
            end
            default: begin
                st_mask  = 4'b1111;
                st_wdata = rs2_q;
            end
        endcase

        use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC ||
                    opcode == OP_JAL);
        use_rs2 = (opcode == OP_BRANCH || opcode == OP_STORE ||
                   opcode == OP_REG);
        use_rd  = !(opcode == OP_BRANCH || opcode == OP_STORE);
        e_bad   = IS_E && ((use_rd && f_rd[4]) || (use_rs1 && f_rs1[4]) ||
                           (use_rs2 && f_rs2[4]));
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        trap_d    = trap_q;
        rf_we     = 1'b0;
        rf_wa     = f_rd[RW-1:0];
        rf_wd     = alu;
        bus_valid = 1'b0;
        bus_addr  = 32'd0;
        bus_wmask = 4'd0;
        bus_wdata = 32'd0;

        unique case (state_q)
            S_FETCH, S_WAIT_INSTR: begin
                bus_valid = 1'b1;
                bus_addr  = pc_q;
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_WAIT_INSTR;
                end
            end
            S_DECODE: begin
                rs1_d = rf_q[f_rs1[RW-1:0]];
                rs2_d = rf_q[f_rs2[RW-1:0]];
                if (e_bad) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OP_LUI: begin
                        rf_we = 1'b1;
                        rf_wd = imm_u;
                    end
                    OP_AUIPC: begin
                        rf_we = 1'b1;
                        rf_wd = pc_q + imm_u;
                    end
                    OP_IMM, OP_REG: rf_we = 1'b1;
                    OP_JAL, OP_JALR: begin
                        if (mis_tgt) begin
                            pc_d    = pc_q;
                            trap_d  = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            rf_we = 1'b1;
                            rf_wd = pc_plus4;
                            pc_d  = tgt;
                        end
                    end
                    OP_BRANCH: begin
                        if (!br_ok || (taken && mis_tgt)) begin
                            pc_d    = pc_q;
                            trap_d  = 1'b1;
                            state_d = S_HALT;
                        end else if (taken) begin
                            pc_d = tgt;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        if (mis_ls || f3 == 3'd3 || f3[2:1] == 2'b11 ||
                            (opcode == OP_STORE && f3[2])) begin
                            pc_d    = pc_q;
                            trap_d  = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            addr_d  = ea;
                            state_d = S_MEM;
                        end
                    end
                    OP_SYSTEM: begin
                        pc_d    = pc_q;
                        trap_d  = (f3 != 3'd0);
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d    = pc_q;
                        trap_d  = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                bus_valid = 1'b1;
                bus_addr  = addr_q;
                if (opcode == OP_STORE) begin
                    bus_wmask = st_mask;
                    bus_wdata = st_wdata;
                end
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = (opcode == OP_STORE) ? S_FETCH : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                rf_we   = 1'b1;
                rf_wd   = ld_val;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_ADDR;
            instr_q <= 32'd0;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            addr_q  <= 32'd0;
            rdata_q <= 32'd0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            trap_q  <= trap_d;
        end
    end

    // x0 is never written, so it reads as zero without masking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && rf_wa != '0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // reset releases the bus in the same cycle, even mid-transaction
    assign mem_valid = resetn & bus_valid;
    assign mem_addr  = resetn ? ({bus_addr[31:2], 2'b00} & AMASK) : 32'd0;
    assign mem_wmask = resetn ? bus_wmask : 4'd0;
    assign mem_wdata = resetn ? bus_wdata : 32'd0;
    assign halted    = (state_q == S_HALT);
    assign trap      = trap_q;
    assign dbg_x1    = rf_q[1];

endmodule
